// File: rtl/nonce_gen_pkg.sv
// Shared types and constants for the multi-lane nonce generator.
package nonce_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RANGE,
    S_ISSUE,
    S_BURST
  } ngmc_state_t;

  localparam int unsigned HDR_WORDS   = 20;
  localparam int unsigned BURST_BEATS = 10;
  localparam logic [63:0] PAD_WORD    = 64'h8000000000000280;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/nonce_lane_ser.sv
// Per-lane frame serializer: latches {header body, byteswapped nonce} on issue
// and shifts it out 64 bits per beat; emits the pad word on the issue cycle.
module nonce_lane_ser
  import nonce_gen_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         active_in,
  input  logic [31:0]  nonce,
  input  logic [607:0] hdr_body,
  input  logic         beat_adv,
  output logic         active,
  output logic         we,
  output logic [63:0]  din
);

  logic [639:0] frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame  <= '0;
      active <= 1'b0;
    end else if (load) begin
      frame  <= {hdr_body, bswap32(nonce)};
      active <= active_in;
    end else if (beat_adv && active) begin
      frame <= {frame[575:0], 64'h0};
    end
  end

  // load and beat_adv are never high together: one is ISSUE-only, the other BURST-only
  always_comb begin
    we  = 1'b0;
    din = '0;
    if (load && active_in) begin
      we  = 1'b1;
      din = PAD_WORD;
    end else if (beat_adv && active) begin
      we  = 1'b1;
      din = frame[639:576];
    end
  end

endmodule

// File: rtl/nonce_gen_mc.sv
// Multi-lane nonce generator: loads an 80-byte header, then sweeps interleaved
// nonces across NUM_LANES hash FIFOs. Optional counters: NONCE_GEN_MC_STATS_EN.
module nonce_gen_mc
  import nonce_gen_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            block_header,
  input  logic                   block_header_we,
  input  logic [31:0]            nonce_size,
  output logic [NUM_LANES-1:0]   hashin_fifo_in_we,
  output logic [NUM_LANES*64-1:0] hashin_fifo_in_din,
  input  logic [NUM_LANES-1:0]   hashin_fifo_in_full,
  output logic                   nonce_fifo_we,
  output logic [NUM_LANES*32-1:0] nonce_fifo_din,
  input  logic                   nonce_fifo_full,
  output logic                   stop_ack_nonce,
  output logic                   done,
  output logic [31:0]            nonce_end
`ifdef NONCE_GEN_MC_STATS_EN
  ,
  output logic [31:0]            frames_sent,
  output logic [31:0]            stall_cycles
`endif
);

  ngmc_state_t  state;
  logic [639:0] hdr;
  logic [4:0]   wcnt;
  logic [3:0]   beat;
  logic         stop_lat;
  logic [32:0]  base;
  logic [32:0]  end33;

  logic [32:0]          sum;
  logic [32:0]          end_sat;
  logic [NUM_LANES-1:0] act_issue;
  logic [NUM_LANES-1:0] act_q;
  logic [32:0]          lane_n [NUM_LANES];
  logic                 in_issue, in_burst, abort, range_left;
  logic                 issue_full, fire, burst_adv;

  assign sum     = {1'b0, hdr[31:0]} + {1'b0, nonce_size};
  assign end_sat = sum[32] ? 33'h1_0000_0000 : sum;

  assign in_issue   = (state == S_ISSUE);
  assign in_burst   = (state == S_BURST);
  assign abort      = stop | stop_lat;
  assign range_left = (base < end33);
  assign issue_full = nonce_fifo_full | (|(act_issue & hashin_fifo_in_full));
  assign fire       = in_issue & ~abort & range_left & ~issue_full;
  assign burst_adv  = in_burst & ~(|(act_q & hashin_fifo_in_full));
  assign nonce_fifo_we = fire;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_n[i]    = base + 33'(i);
    assign act_issue[i] = (lane_n[i] < end33);
    assign nonce_fifo_din[32*i +: 32] = (fire && act_issue[i]) ? lane_n[i][31:0] : '0;

    nonce_lane_ser u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (fire),
      .active_in(act_issue[i]),
      .nonce    (lane_n[i][31:0]),
      .hdr_body (hdr[639:32]),
      .beat_adv (burst_adv),
      .active   (act_q[i]),
      .we       (hashin_fifo_in_we[i]),
      .din      (hashin_fifo_in_din[64*i +: 64])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      hdr            <= '0;
      wcnt           <= '0;
      beat           <= '0;
      stop_lat       <= 1'b0;
      base           <= '0;
      end33          <= '0;
      stop_ack_nonce <= 1'b0;
      done           <= 1'b0;
      nonce_end      <= '0;
    end else begin
      done           <= 1'b0;
      stop_ack_nonce <= 1'b0;
      case (state)
        S_IDLE: begin
          hdr            <= '0;
          wcnt           <= '0;
          stop_lat       <= 1'b0;
          stop_ack_nonce <= ~start;
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (block_header_we) begin
            hdr  <= {block_header, hdr[639:32]};
            wcnt <= wcnt + 5'd1;
            if (wcnt == 5'(HDR_WORDS - 1)) state <= S_RANGE;
          end
        end
        S_RANGE: begin
          base      <= {1'b0, hdr[31:0]};
          end33     <= end_sat;
          nonce_end <= end_sat[31:0];
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (abort) begin
            state          <= S_IDLE;
            stop_ack_nonce <= 1'b1;
          end else if (!range_left) begin
            done           <= 1'b1;
            state          <= S_IDLE;
            stop_ack_nonce <= 1'b1;
          end else if (fire) begin
            base  <= base + 33'(NUM_LANES);
            beat  <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          // stop only takes effect at the next ISSUE so every frame stays 11 words
          if (stop) stop_lat <= 1'b1;
          if (burst_adv) begin
            beat <= beat + 4'd1;
            if (beat == 4'(BURST_BEATS - 1)) state <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NONCE_GEN_MC_STATS_EN
  logic blocked;
  assign blocked = (in_issue & ~abort & range_left & issue_full) | (in_burst & ~burst_adv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_sent  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == S_IDLE) frames_sent <= '0;
      else if (fire) frames_sent <= frames_sent + 32'd1;
      if (blocked && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nonce_gen_mc.sv
// Directed bench for nonce_gen_mc (4 lanes): vector table plus stall/stop/reset sequences.
module tb_nonce_gen_mc;

  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, stop;
  logic [31:0]     block_header;
  logic            block_header_we;
  logic [31:0]     nonce_size;
  logic [NL-1:0]   hashin_fifo_in_we;
  logic [NL*64-1:0] hashin_fifo_in_din;
  logic [NL-1:0]   hashin_fifo_in_full;
  logic            nonce_fifo_we;
  logic [NL*32-1:0] nonce_fifo_din;
  logic            nonce_fifo_full;
  logic            stop_ack_nonce;
  logic            done;
  logic [31:0]     nonce_end;

  nonce_gen_mc #(.NUM_LANES(NL)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .block_header       (block_header),
    .block_header_we    (block_header_we),
    .nonce_size         (nonce_size),
    .hashin_fifo_in_we  (hashin_fifo_in_we),
    .hashin_fifo_in_din (hashin_fifo_in_din),
    .hashin_fifo_in_full(hashin_fifo_in_full),
    .nonce_fifo_we      (nonce_fifo_we),
    .nonce_fifo_din     (nonce_fifo_din),
    .nonce_fifo_full    (nonce_fifo_full),
    .stop_ack_nonce     (stop_ack_nonce),
    .done               (done),
    .nonce_end          (nonce_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      size;
    int               groups;
    logic [3:0][7:0]  wr;
    int               dones;
    logic [31:0]      nend;
    logic [127:0]     first_grp;
    logic [127:0]     last_grp;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hdr_cyc;
  int first_we_cyc;
  int lcnt [NL];
  logic [63:0]  lane_log [NL][64];
  logic [127:0] grp_log [8];
  int gcnt, dcnt, viol;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (hashin_fifo_in_we[i]) begin
        if (lcnt[i] < 64) lane_log[i][lcnt[i]] = hashin_fifo_in_din[64*i +: 64];
        lcnt[i]++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
      end else if (hashin_fifo_in_din[64*i +: 64] != 64'h0) viol++;
    end
    if (nonce_fifo_we) begin
      if (gcnt < 8) grp_log[gcnt] = nonce_fifo_din;
      gcnt++;
    end else if (nonce_fifo_din != '0) viol++;
    if (done) dcnt++;
  end

  function automatic logic [31:0] tb_bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] hw(input logic [31:0] base, input int k);
    return (k == 0) ? base : (32'hA000_0000 | 32'(k));
  endfunction

  // Frame word b of a frame carrying nonce n: pad, then header words 19..2 in pairs, then {w1, bswap(n)}
  function automatic logic [63:0] exp_word(input logic [31:0] base, input int b, input logic [31:0] n);
    if (b == 0) return 64'h8000000000000280;
    if (b == 10) return {hw(base, 1), tb_bswap(n)};
    return {hw(base, 21 - 2*b), hw(base, 20 - 2*b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NL; i++) lcnt[i] = 0;
    gcnt = 0; dcnt = 0; viol = 0; first_we_cyc = -1;
  endtask

  task automatic load_hdr(input logic [31:0] base, input logic [31:0] size);
    nonce_size = size;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      block_header = hw(base, k);
      block_header_we = 1'b1;
      if (k == 19) last_hdr_cyc = cyc;
      tick();
    end
    block_header_we = 1'b0;
    block_header = '0;
  endtask

  task automatic wait_cnt(input int n, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (lcnt[0] >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_reach_beat"}, ok, 1'b1);
  endtask

  task automatic post_check(input vec_t v, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (stop_ack_nonce) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle_timeout"}, ok, 1'b1);
    tick();
    tick();
    chk({tag, "_nonce_end"}, nonce_end, v.nend);
    chk({tag, "_done_cnt"}, dcnt, v.dones);
    chk({tag, "_groups"}, gcnt, v.groups);
    chk({tag, "_din_zero"}, viol, 0);
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s_wr_l%0d", tag, i), lcnt[i], v.wr[i]);
    if (v.groups > 0) begin
      chk({tag, "_first_grp"}, grp_log[0], v.first_grp);
      chk({tag, "_last_grp"}, grp_log[v.groups-1], v.last_grp);
      chk({tag, "_hdr_to_pad"}, first_we_cyc - last_hdr_cyc, 2);
    end
    for (int i = 0; i < NL; i++)
      for (int f = 0; f < lcnt[i] / 11 && f < 5; f++)
        for (int b = 0; b < 11; b++)
          chk($sformatf("%s_l%0d_f%0d_b%0d", tag, i, f, b), lane_log[i][11*f+b],
              exp_word(v.base, b, v.base + 32'(4*f + i)));
  endtask

  vec_t vecs[5];
  vec_t vbp, vstop;
  int   tot;

  initial begin
    vecs[0] = '{32'h10, 32'd8, 2, {8'd22, 8'd22, 8'd22, 8'd22}, 1, 32'h18,
                {32'h13, 32'h12, 32'h11, 32'h10}, {32'h17, 32'h16, 32'h15, 32'h14}};
    vecs[1] = '{32'h10, 32'd6, 2, {8'd11, 8'd11, 8'd22, 8'd22}, 1, 32'h16,
                {32'h13, 32'h12, 32'h11, 32'h10}, {32'h0, 32'h0, 32'h15, 32'h14}};
    vecs[2] = '{32'hFFFF_FFFE, 32'd10, 1, {8'd0, 8'd0, 8'd11, 8'd11}, 1, 32'h0,
                {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
    vecs[3] = '{32'h1234, 32'd0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 32'h1234, '0, '0};
    vecs[4] = '{32'h100, 32'd5, 2, {8'd11, 8'd11, 8'd11, 8'd22}, 1, 32'h105,
                {32'h103, 32'h102, 32'h101, 32'h100}, {32'h0, 32'h0, 32'h0, 32'h104}};
    vbp     = '{32'h10, 32'd4, 1, {8'd11, 8'd11, 8'd11, 8'd11}, 1, 32'h14,
                {32'h13, 32'h12, 32'h11, 32'h10}, {32'h13, 32'h12, 32'h11, 32'h10}};
    vstop   = '{32'h10, 32'd8, 1, {8'd11, 8'd11, 8'd11, 8'd11}, 0, 32'h18,
                {32'h13, 32'h12, 32'h11, 32'h10}, {32'h13, 32'h12, 32'h11, 32'h10}};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; block_header = '0; block_header_we = 1'b0;
    nonce_size = '0; hashin_fifo_in_full = '0; nonce_fifo_full = 1'b0;
    clear_logs();
    repeat (3) tick();
    chk("rst_we", {hashin_fifo_in_we, nonce_fifo_we}, '0);
    chk("rst_din", hashin_fifo_in_din, '0);
    chk("rst_ndin", nonce_fifo_din, '0);
    chk("rst_ack", stop_ack_nonce, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_nend", nonce_end, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_ack", stop_ack_nonce, 1'b1);

    for (int v = 0; v < 5; v++) begin
      clear_logs();
      load_hdr(vecs[v].base, vecs[v].size);
      post_check(vecs[v], $sformatf("vec%0d", v));
    end

    // Backpressure: lane 2 full for 5 cycles starting at beat 4
    clear_logs();
    load_hdr(vbp.base, vbp.size);
    wait_cnt(4, "bp");
    tick();
    hashin_fifo_in_full[2] = 1'b1;
    tot = lcnt[0] + lcnt[1] + lcnt[2] + lcnt[3];
    chk("bp_before", tot, 16);
    repeat (5) tick();
    chk("bp_stalled", lcnt[0] + lcnt[1] + lcnt[2] + lcnt[3], tot);
    hashin_fifo_in_full[2] = 1'b0;
    post_check(vbp, "bp");

    // Stop pulsed during beat 3: frame completes, no second group, no done
    clear_logs();
    load_hdr(vstop.base, vstop.size);
    wait_cnt(3, "stop");
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_cnt(11, "stop");
    @(negedge clk);
    chk("stop_issue_ack", stop_ack_nonce, 1'b0);
    chk("stop_issue_we", {hashin_fifo_in_we, nonce_fifo_we}, '0);
    @(negedge clk);
    chk("stop_idle_ack", stop_ack_nonce, 1'b1);
    post_check(vstop, "stop");

    // Reset mid-burst, then a normal run
    clear_logs();
    load_hdr(vecs[0].base, vecs[0].size);
    wait_cnt(5, "mrst");
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_we", {hashin_fifo_in_we, nonce_fifo_we}, '0);
    chk("mrst_din", hashin_fifo_in_din, '0);
    chk("mrst_ndin", nonce_fifo_din, '0);
    chk("mrst_ack", stop_ack_nonce, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_nend", nonce_end, '0);
    rst_n = 1'b1;
    tick();
    clear_logs();
    load_hdr(vecs[0].base, vecs[0].size);
    post_check(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
